// File: rtl/arm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multicycle ARM control path:
//   - state_t      : controller FSM states
//   - ALU_*        : ALUControl codes understood by the datapath ALU
//   - OP_*         : instruction class encodings (Instr[27:26])
//   - CMD_*        : data-processing cmd field encodings (Instr[24:21])
//   - COND_*       : condition-code encodings (Instr[31:28])
//   - decode_cmd   : maps a DP cmd onto ALU code / flag-source / write info
//   - imm_src_of / reg_src_of : per-class immediate and register-port selects
// No ports (package).
// -----------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b0101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [3:0] alu;      // ALUControl code
        logic       arith;    // flags come from the ALU (C/V meaningful)
        logic       known;    // supported cmd; unknown cmds never touch flags
        logic       nowrite;  // compare-only, no register writeback
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        case (cmd)
            CMD_ADD: d = '{alu: ALU_ADD, arith: 1'b1, known: 1'b1, nowrite: 1'b0};
            CMD_SUB: d = '{alu: ALU_SUB, arith: 1'b1, known: 1'b1, nowrite: 1'b0};
            CMD_CMP: d = '{alu: ALU_SUB, arith: 1'b1, known: 1'b1, nowrite: 1'b1};
            CMD_AND: d = '{alu: ALU_AND, arith: 1'b0, known: 1'b1, nowrite: 1'b0};
            CMD_ORR: d = '{alu: ALU_ORR, arith: 1'b0, known: 1'b1, nowrite: 1'b0};
            CMD_EOR: d = '{alu: ALU_EOR, arith: 1'b0, known: 1'b1, nowrite: 1'b0};
            CMD_MOV: d = '{alu: ALU_MOV, arith: 1'b0, known: 1'b1, nowrite: 1'b0};
            default: d = '{alu: ALU_MOV, arith: 1'b0, known: 1'b0, nowrite: 1'b0};
        endcase
        return d;
    endfunction

    // Immediate extension format for each instruction class.
    function automatic logic [1:0] imm_src_of(input logic [1:0] op);
        case (op)
            OP_MEM:  return 2'b01;
            OP_BR:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // RegSrc[0]: branches read PC (R15) on the Rn port.
    // RegSrc[1]: stores read Rd on the second port to supply write data.
    function automatic logic [1:0] reg_src_of(input logic [1:0] op);
        return {op == OP_MEM, op == OP_BR};
    endfunction

endpackage

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Architectural NZCV flag register with load enable, plus combinational
// evaluation of the instruction condition field against the registered flags.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears flags)
//   flag_we     : load alu_flags into the flag register at the clock edge
//   alu_flags   : NZCV from the datapath flag mux ([3]=N [2]=Z [1]=C [0]=V)
//   cond        : Instr[31:28]
//   cond_ex     : 1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_logic
    import arm_ctrl_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [3:0]        cond,
    output logic              cond_ex
);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic n, z, c, v;

    always_comb begin
        flags_d = flag_we ? alu_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign n = flags_q[3];
    assign z = flags_q[2];
    assign c = flags_q[1];
    assign v = flags_q[0];

    // Cond=1111 (never) falls into the default.
    always_comb begin
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle ARM control FSM: FETCH, DECODE, then per-class execute/writeback
// states. Drives every datapath select/enable, owns the NZCV flag register
// (via cond_logic) and squashes instructions whose condition fails.
// Optional build macro MULTICYCLE_MEM_WAIT_EN: FETCH, MEMRD and MEMWR hold
// until MemReady=1. Without it MemReady is ignored (single-cycle memory).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   Cond, Op, Funct, Rd    : instruction register fields
//   ALUFlags               : NZCV from the datapath flag mux
//   MemReady               : memory handshake (wait build only)
//   PCWrite, IRWrite, MemWrite, RegWrite : enables (forced 0 in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl,
//   ShifterSrc             : datapath selects
//   StateOut               : current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int FLAG_W   = 4,
    parameter int ALUCTL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          Cond,
    input  logic [1:0]          Op,
    input  logic [5:0]          Funct,
    input  logic [3:0]          Rd,
    input  logic [FLAG_W-1:0]   ALUFlags,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmSrc,
    output logic [1:0]          RegSrc,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                ShifterSrc,
    output logic [3:0]          StateOut
);

    state_t   state_q;
    state_t   state_d;
    cmd_dec_t dec;
    logic     cond_ex;
    logic     flag_we;
    logic     mem_ready;
    logic     is_imm;
    logic     set_flags;
    logic     is_load;
    logic     rd_is_pc;
    logic [3:0] alu_sel;

    assign is_imm    = Funct[5];
    assign set_flags = Funct[0];
    assign is_load   = Funct[0];
    assign rd_is_pc  = (Rd == 4'hF);
    assign dec       = decode_cmd(Funct[4:1]);

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ready        = 1'b1;
`endif

    // Unsupported cmds execute as MOV but must leave the flags alone.
    assign flag_we = ~reset & set_flags & dec.known &
                     ((state_q == EXECR) | (state_q == EXECI));

    cond_logic #(
        .FLAG_W (FLAG_W)
    ) u_cond (
        .clk       (clk),
        .reset     (reset),
        .flag_we   (flag_we),
        .alu_flags (ALUFlags),
        .cond      (Cond),
        .cond_ex   (cond_ex)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (Op)
                        OP_MEM:  state_d = MEMADR;
                        OP_BR:   state_d = BRANCH;
                        OP_DP:   state_d = is_imm ? EXECI : EXECR;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: state_d = is_load ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXECR,
            EXECI:  state_d = dec.nowrite ? FETCH : ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ShifterSrc = 1'b0;
        alu_sel    = ALU_ADD;

        // ExtImm and register reads come straight off the IR, so the
        // per-class selects stay valid for every state after the IR load.
        if (state_q != FETCH) begin
            ImmSrc = imm_src_of(Op);
            RegSrc = reg_src_of(Op);
        end

        case (state_q)
            FETCH: begin
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = rd_is_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_sel    = dec.alu;
                ShifterSrc = dec.arith;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                PCWrite  = rd_is_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase

        ALUControl = ALUCTL_W'(alu_sel);

        if (reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
            ShifterSrc = 1'b0;
            ALUControl = '0;
        end
    end

    assign StateOut = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each step carries the instruction,
// reset/MemReady/ALUFlags drive and the expected packed output vector; steps
// are queued per instruction and compared one per clock at the falling edge.
// Optional macro MULTICYCLE_MEM_WAIT_EN selects the memory-wait scenario.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ShifterSrc;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl;
    logic [3:0] StateOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.FLAG_W(4), .ALUCTL_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .ShifterSrc(ShifterSrc), .StateOut(StateOut)
    );

    // {StateOut, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
    //  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, ShifterSrc}
    logic [22:0] obs;
    assign obs = {StateOut, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, ShifterSrc};

    typedef struct {
        logic [31:0] ins;
        logic        rst;
        logic        rdy;
        logic [3:0]  flg;
        logic [22:0] exp;
        string       tag;
    } step_t;

    step_t sb[$];

    localparam logic [3:0] FX = 4'b1111;  // flags driven outside EXEC states

    function automatic logic [22:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic irw, input logic memw, input logic regw,
                                       input logic [1:0] rs, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] imm, input logic [1:0] rsrc,
                                       input logic [3:0] alu, input logic shs);
        return {st, pcw, adr, irw, memw, regw, rs, asa, asb, imm, rsrc, alu, shs};
    endfunction

    function automatic logic [1:0] imm_exp(input logic [1:0] op);
        if (op == 2'b01) return 2'b01;
        if (op == 2'b10) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] rsrc_exp(input logic [1:0] op);
        return {op == 2'b01, op == 2'b10};
    endfunction

    function automatic logic [22:0] e_fetch(input logic go);
        return ev(FETCH, go, 0, go, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, ALU_ADD, 0);
    endfunction

    function automatic logic [22:0] e_decode(input logic [1:0] op);
        return ev(DECODE, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, imm_exp(op), rsrc_exp(op), ALU_ADD, 0);
    endfunction

    task automatic push(input logic [31:0] ins, input logic rst, input logic rdy,
                        input logic [3:0] flg, input logic [22:0] e, input string tag);
        step_t s;
        s.ins = ins; s.rst = rst; s.rdy = rdy; s.flg = flg; s.exp = e; s.tag = tag;
        sb.push_back(s);
    endtask

    task automatic run_sb();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            Cond     = s.ins[31:28];
            Op       = s.ins[27:26];
            Funct    = s.ins[25:20];
            Rd       = s.ins[15:12];
            reset    = s.rst;
            MemReady = s.rdy;
            ALUFlags = s.flg;
            @(negedge clk);
            checks++;
            assert (obs === s.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Data-processing instruction; alu/shs/nowrite are the expected decode.
    task automatic dp(input logic [31:0] ins, input logic [3:0] alu, input logic shs,
                      input logic nowrite, input logic [3:0] flg, input string tag);
        logic [3:0] st;
        st = ins[25] ? EXECI : EXECR;
        push(ins, 0, 1, FX, e_fetch(1), {tag, ".fetch"});
        push(ins, 0, 1, FX, e_decode(2'b00), {tag, ".decode"});
        push(ins, 0, 1, flg, ev(st, 0, 0, 0, 0, 0, 2'b00, 0, ins[25] ? 2'b01 : 2'b00,
                                 2'b00, 2'b00, alu, shs), {tag, ".exec"});
        if (!nowrite)
            push(ins, 0, 1, FX, ev(ALUWB, ins[15:12] == 4'hF, 0, 0, 0, 1, 2'b00, 0, 2'b00,
                                   2'b00, 2'b00, ALU_ADD, 0), {tag, ".aluwb"});
        run_sb();
    endtask

    // Memory instruction; fwaits/waits = held FETCH / access cycles,
    // rdy_last = MemReady in the completing access cycle.
    task automatic mem(input logic [31:0] ins, input int fwaits, input int waits,
                       input logic rdy_last, input string tag);
        logic [3:0] acc;
        logic [22:0] e_acc;
        acc   = ins[20] ? MEMRD : MEMWR;
        e_acc = ev(acc, 0, 1, 0, !ins[20], 0, 2'b00, 0, 2'b00, 2'b01, 2'b10, ALU_ADD, 0);
        for (int i = 0; i < fwaits; i++)
            push(ins, 0, 0, FX, e_fetch(0), {tag, ".fetch_hold"});
        push(ins, 0, 1, FX, e_fetch(1), {tag, ".fetch"});
        push(ins, 0, 1, FX, e_decode(2'b01), {tag, ".decode"});
        push(ins, 0, 1, FX, ev(MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10, ALU_ADD, 0),
             {tag, ".memadr"});
        for (int i = 0; i < waits; i++)
            push(ins, 0, 0, FX, e_acc, {tag, ".acc_hold"});
        push(ins, 0, rdy_last, FX, e_acc, {tag, ".acc"});
        if (ins[20])
            push(ins, 0, 1, FX, ev(MEMWB, ins[15:12] == 4'hF, 0, 0, 0, 1, 2'b01, 0, 2'b00,
                                   2'b01, 2'b10, ALU_ADD, 0), {tag, ".memwb"});
        run_sb();
    endtask

    // Branch; not-taken ends after DECODE (next fetch proves the return).
    task automatic br(input logic [31:0] ins, input logic taken, input string tag);
        push(ins, 0, 1, FX, e_fetch(1), {tag, ".fetch"});
        push(ins, 0, 1, FX, e_decode(ins[27:26]), {tag, ".decode"});
        if (taken)
            push(ins, 0, 1, FX, ev(BRANCH, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b10, 2'b01, ALU_ADD, 0),
                 {tag, ".branch"});
        run_sb();
    endtask

    initial begin
        reset = 1'b1; Cond = '0; Op = '0; Funct = '0; Rd = '0;
        ALUFlags = '0; MemReady = 1'b1;
        @(posedge clk);
        #1;

        // Held in reset: state FETCH, every output low.
        push(32'h0, 1, 1, FX, ev(FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0),
             "reset_idle");
        run_sb();

        // Flags are 0000 after reset: EQ squashed, NE taken.
        br(32'h0A000002, 0, "beq_reset");
        br(32'h1A000002, 1, "bne_reset");

        dp(32'hE0821003, ALU_ADD, 1, 0, 4'b0000, "add");
        mem(32'hE5904008, 0, 0, 1'b1, "ldr");
        mem(32'hE5804008, 0, 0, 1'b1, "str");

        dp(32'hE1510001, ALU_SUB, 1, 1, 4'b0100, "cmp");
        br(32'h0A000002, 1, "beq");
        br(32'h1A000002, 0, "bne");

        // Unsupported cmd with S=1: runs as MOV, flags untouched.
        dp(32'hE0F12003, ALU_MOV, 0, 0, 4'b1111, "rsc_as_mov");
        br(32'h4A000002, 0, "bmi_after_mov");
        br(32'h0A000002, 1, "beq_after_mov");

        // ADDS loads N=1: MI taken, EQ not, LT (N!=V) taken, GE not.
        dp(32'hE0921003, ALU_ADD, 1, 0, 4'b1000, "adds");
        br(32'h4A000002, 1, "bmi");
        br(32'h0A000002, 0, "beq_nt");
        br(32'hBA000002, 1, "blt");
        br(32'hAA000002, 0, "bge_nt");

        dp(32'hE0412003, ALU_SUB, 1, 0, 4'b0000, "sub");
        dp(32'hE0012003, ALU_AND, 0, 0, 4'b0000, "and");
        dp(32'hE0212003, ALU_EOR, 0, 0, 4'b0000, "eor");
        dp(32'hE1A02003, ALU_MOV, 0, 0, 4'b0000, "mov");
        dp(32'hE38FF0FF, ALU_ORR, 0, 0, 4'b0000, "orr_imm_pc");

        // Undefined Op=11 and Cond=1111 both return to FETCH after DECODE.
        push(32'hEC000000, 0, 1, FX, e_fetch(1), "undef_op.fetch");
        push(32'hEC000000, 0, 1, FX, e_decode(2'b11), "undef_op.decode");
        run_sb();
        br(32'hF0821003, 0, "cond_never");

`ifdef MULTICYCLE_MEM_WAIT_EN
        // One held FETCH, then MEMRD waits three cycles before MemReady.
        mem(32'hE5904008, 1, 3, 1'b1, "ldr_wait");
        mem(32'hE5804008, 0, 2, 1'b1, "str_wait");
`else
        // MemReady low is ignored: LDR still completes in five cycles.
        mem(32'hE5904008, 0, 0, 1'b0, "ldr_noready");
`endif

        // Reset during MEMWR: no write, back to FETCH, flags (N=1) cleared.
        push(32'hE5804008, 0, 1, FX, e_fetch(1), "str_rst.fetch");
        push(32'hE5804008, 0, 1, FX, e_decode(2'b01), "str_rst.decode");
        push(32'hE5804008, 0, 1, FX, ev(MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b10,
                                        ALU_ADD, 0), "str_rst.memadr");
        push(32'hE5804008, 1, 1, FX, ev(MEMWR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00,
                                        4'h0, 0), "str_rst.reset");
        run_sb();
        br(32'h4A000002, 0, "bmi_after_rst");
        br(32'h5A000002, 1, "bpl_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the ARM datapath over multiple cycles: FETCH, DECODE, then per-class execute and writeback states.
- Takes Op/Funct/Rd/Cond from the instruction register and NZCV flags from the ALU/shifter flag mux.
- Drives all datapath select and enable lines. Holds the architectural flags register and evaluates the condition code.
- Sits beside the datapath and replaces the single-cycle combinational decoder.

Parameters:
- FLAG_W, 4, width of NZCV flags.
- ALUCTL_W, 4, width of ALUControl.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (or L for memory)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from datapath flag mux
- MemReady  in  1  memory done (used only with MEM_WAIT_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0=PC, 1=ALUOut
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  data memory write
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  1  0=Rn, 1=PC
- ALUSrcB  out  2  00 Rm/shifted, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
- RegSrc  out  2  as in the datapath
- ALUControl  out  4  package ALU code
- ShifterSrc  out  1  flag source select (0 shifter, 1 ALU)
- StateOut  out  4  current state, debug only

Behaviour:
- Reset:
  - state <= FETCH; flag register <= 0000.
  - While reset is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0. Select outputs are 0.
  - Reset mid-instruction discards that instruction; no partial write occurs in the reset cycle.
- Outputs are a Moore decode of state, except where noted below.
- FETCH:
  - AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (forms PC+8). ImmSrc and RegSrc are driven from Op.
  - CondEx=0: next state FETCH (instruction squashed).
  - Otherwise next state by class: Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00 with I=1 -> EXECI; Op=00 with I=0 -> EXECR.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD. Next: MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUControl from cmd.
  - If S=1, the flag register loads ALUFlags at the end of the cycle. ShifterSrc=1 for arithmetic cmds, 0 for logical/MOV.
  - Next: ALUWB, or FETCH if cmd=CMP (NoWrite).
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next: FETCH.
- Rd=15 in MEMWB/ALUWB: also assert PCWrite (result written to PC).
- cmd mapping:
  - 0100 -> ADD; 0010 -> SUB; 1010 (CMP) -> SUB; 0000 -> AND; 1100 -> ORR; 0001 -> EOR; 1101 -> MOV.
  - Any other cmd: treated as MOV, no flag update.
- Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL are evaluated on the registered flags. Cond=1111 is treated as never.
- Undefined Op=11: DECODE -> FETCH, no side effects.
- Latency: branch 3 cycles, DP 4, CMP 3, STR 4, LDR 5.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined:
  - FETCH holds (IRWrite and PCWrite low) until MemReady=1; the IRWrite/PCWrite pulse occurs in the MemReady cycle.
  - MEMRD and MEMWR hold until MemReady=1. MemWrite stays high while held.
  - Reset still overrides the hold.
- Undefined: MemReady is ignored and every memory access takes one cycle.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH);
  - ALU codes ADD=0000, SUB=0001, AND=0010, ORR=0011, EOR=0100, MOV=0101;
  - Op encodings; cond-code constants.
- Sub-module cond_logic: registered NZCV with load enable plus combinational CondEx.

Test Plan:
- Reset, then release -> StateOut=FETCH, PCWrite=1 and IRWrite=1 in the first cycle, flags=0000.
- ADD R1,R2,R3 (E0821003) -> states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4; ALUControl=0000 in EXECR.
- LDR R4,[R0,#8] (E5904008) -> 5 states; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (E5804008) -> MemWrite=1 only in MEMWR.
- CMP R1,R1 (E1510001) with ALUFlags=0100 -> flags become Z=1, no RegWrite. Then BEQ (0A000002) takes 3 states with PCWrite in BRANCH. Then BNE (1A000002) -> DECODE returns to FETCH with no PCWrite.
- Reset asserted in MEMWR -> MemWrite=0 that cycle, next state FETCH, flags cleared.
- MULTICYCLE_MEM_WAIT_EN with MemReady low for 3 cycles during an LDR's MEMRD -> 3 extra MEMRD cycles, then MEMWB; total 8 cycles.
